// File: rtl/inv_key_expansion.sv
// Iterative inverse AES-128 key schedule: regenerates round keys 10 down to 0 from the round-10 key.
// Optional INV_KEY_MIXCOL_EN presents InvMixColumns of keys 9..1 for the equivalent inverse cipher.
module inv_key_expansion (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] last_key,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    localparam logic [0:2047] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state_q;
    logic [0:127] key_q;
    logic [0:127] prev_d;
    logic [3:0]   idx_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;
    logic         load;
    logic         step;

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] p0, p1, p2, p3;
    logic [0:31] rot, sub;

    // Undo one forward expansion round: w[i-4] = w[i] ^ w[i-1], with the g() term on the first word.
    always_comb begin
        w0     = key_q[0:31];
        w1     = key_q[32:63];
        w2     = key_q[64:95];
        w3     = key_q[96:127];
        p3     = w3 ^ w2;
        p2     = w2 ^ w1;
        p1     = w1 ^ w0;
        rot    = {p3[8:31], p3[0:7]};
        sub    = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])};
        p0     = w0 ^ sub ^ {rcon(idx_q), 24'h000000};
        prev_d = {p0, p1, p2, p3};
    end

    assign load = (state_q == IDLE) && start;
    assign step = (state_q == EMIT) && valid_q && key_ready && (idx_q != 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        key_q   <= last_key;
                        idx_q   <= 4'd10;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (valid_q && key_ready) begin
                        if (idx_q != 4'd0) begin
                            key_q <= prev_d;
                            idx_q <= idx_q - 4'd1;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef INV_KEY_MIXCOL_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 14*a ^ 11*b ^ 13*c ^ 9*d in GF(2^8)
    function automatic logic [7:0] imc_byte(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        logic [7:0] a2, a4, a8, b2, b8, c4, c8, d8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        b2 = xt(b);
        b8 = xt(xt(b2));
        c4 = xt(xt(c));
        c8 = xt(c4);
        d8 = xt(xt(xt(d)));
        return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    endfunction

    function automatic logic [0:31] imc_col(input logic [0:31] c);
        return {imc_byte(c[0:7],   c[8:15],  c[16:23], c[24:31]),
                imc_byte(c[8:15],  c[16:23], c[24:31], c[0:7]),
                imc_byte(c[16:23], c[24:31], c[0:7],   c[8:15]),
                imc_byte(c[24:31], c[0:7],   c[8:15],  c[16:23])};
    endfunction

    logic [0:127] out_q;

    // Separate output register so the schedule state stays untransformed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q <= '0;
        end else if (load) begin
            out_q <= last_key;
        end else if (step) begin
            if (idx_q == 4'd1)
                out_q <= prev_d;
            else
                out_q <= {imc_col(prev_d[0:31]), imc_col(prev_d[32:63]),
                          imc_col(prev_d[64:95]), imc_col(prev_d[96:127])};
        end
    end

    assign round_key = out_q;
`else
    assign round_key = key_q;
`endif

    assign round_idx = idx_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed bench for inv_key_expansion: FIPS-197 and zero-key schedules, stalls, start-while-busy, reset.
// Define INV_KEY_MIXCOL_EN for both RTL and bench to check the InvMixColumns build.
module tb_inv_key_expansion;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [0:127] last_key;
    logic [0:127] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_key_expansion dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .last_key  (last_key),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

`ifdef INV_KEY_MIXCOL_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] v);
        logic [7:0]   m [0:3] = '{8'd14, 8'd11, 8'd13, 8'd9};
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(v[127 - 8 * (4 * c + k) -: 8], m[(k - row + 4) % 4]);
                r[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        return r;
    endfunction
`endif

    // sel 0: FIPS-197 schedule; sel 1: zero-key schedule (only rounds 10, 1, 0 tabulated)
    function automatic logic [127:0] exp_key(input int sel, input int idx);
        logic [127:0] base;
        if (sel == 0)       base = fips_rk[idx];
        else if (idx == 10) base = ZERO_RK10;
        else if (idx == 1)  base = ZERO_RK1;
        else                base = '0;
`ifdef INV_KEY_MIXCOL_EN
        if (idx >= 1 && idx <= 9) base = ref_imc(base);
`endif
        return base;
    endfunction

    task automatic run_seq(input logic [127:0] key, input int sel, input int stall_mask,
                           input int poke_idx, input int rst_idx);
        start    = 1'b1;
        last_key = key;
        @(posedge clk); #1;
        start    = 1'b0;
        last_key = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
        for (int i = 10; i >= 0; i--) begin
            if (sel == 0 || i == 10 || i <= 1)
                check($sformatf("key%0d", i), round_key, exp_key(sel, i));
            check($sformatf("idx%0d", i), 128'(round_idx), 128'(i));
            check($sformatf("valid%0d", i), 128'(key_valid), 128'(1));
            check($sformatf("busy%0d", i), 128'(busy), 128'(1));
            check($sformatf("done_early%0d", i), 128'(done), 128'(0));
            if (i == rst_idx) begin
                reset = 1'b0;
                @(posedge clk); #1;
                check("rst_key", round_key, 128'(0));
                check("rst_idx", 128'(round_idx), 128'(0));
                check("rst_valid", 128'(key_valid), 128'(0));
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_done", 128'(done), 128'(0));
                reset = 1'b1;
                @(posedge clk); #1;
                check("post_rst_done", 128'(done), 128'(0));
                check("post_rst_valid", 128'(key_valid), 128'(0));
                return;
            end
            if (stall_mask[i]) begin
                key_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check($sformatf("stall_key%0d", i), round_key, exp_key(sel, i));
                    check($sformatf("stall_idx%0d", i), 128'(round_idx), 128'(i));
                    check($sformatf("stall_done%0d", i), 128'(done), 128'(0));
                end
                key_ready = 1'b1;
            end
            if (i == poke_idx) begin
                start    = 1'b1;
                last_key = 128'h00112233445566778899aabbccddeeff;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("done_pulse", 128'(done), 128'(1));
        check("done_valid", 128'(key_valid), 128'(0));
        check("done_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check("done_clear", 128'(done), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_valid", 128'(key_valid), 128'(0));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b1;
        last_key  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_key", round_key, 128'(0));
        check("reset_idx", 128'(round_idx), 128'(0));
        check("reset_valid", 128'(key_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", 128'(key_valid), 128'(0));

        run_seq(fips_rk[10], 0, 0, -1, -1);
        run_seq(ZERO_RK10, 1, 0, -1, -1);
        run_seq(fips_rk[10], 0, (1 << 7) | 1, -1, -1);
        run_seq(fips_rk[10], 0, 0, 5, -1);
        run_seq(fips_rk[10], 0, 0, -1, 4);
        run_seq(fips_rk[10], 0, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_key_expansion.md
# inv_key_expansion

Iterative inverse AES-128 key schedule. It takes the final (round-10) round key and regenerates the round keys in reverse order, round 10 down to round 0, one key per valid/ready handshake. It sits in front of the decryption datapath, so decryption needs neither the full 1408-bit expanded key vector nor the original cipher key.

## Interface

**Parameters**
- None. AES-128 only: 128-bit key, 11 round keys.

**Ports**
- `clk`  input  1  Single clock; all state updates on its rising edge.
- `reset`  input  1  Synchronous, active-low. Sampled on `posedge clk`; `reset==0` clears all state.
- `start`  input  1  Request a new sequence. Accepted only in `IDLE`.
- `last_key`  input  [0:127]  Round-10 key, bit 0 = MSB. Sampled on the cycle `start` is accepted.
- `round_key`  output  [0:127]  Current round key, registered.
- `round_idx`  output  [3:0]  Round number of `round_key` (10..0).
- `key_valid`  output  1  `round_key` and `round_idx` are valid.
- `key_ready`  input  1  Consumer accepts the key on a cycle where `key_valid && key_ready`.
- `busy`  output  1  High from start acceptance until the round-0 key is accepted.
- `done`  output  1  One-cycle pulse after the round-0 key is accepted.

## Operation

- **States:** `IDLE`, `EMIT`, `FIN`.
- **IDLE:**
  - On `start==1`, load `last_key` into the internal state.
  - Set `round_idx=10`, `key_valid=1`, `busy=1`, and go to `EMIT`.
- **EMIT:**
  - Outputs hold stable while `key_valid && !key_ready`.
  - On a handshake with `round_idx>0`, compute the previous key from the current words w0..w3:
    - p3 = w3^w2
    - p2 = w2^w1
    - p1 = w1^w0
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[round_idx],24'h0}
  - Register p0..p3 and decrement `round_idx`.
- **Rcon** by round 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Byte arithmetic is in GF(2^8); no carries.
- **SubWord:** four combinational forward S-box lookups on p3 after RotWord. RotWord is a 1-byte left rotate.
- **Round-0 handshake:** clear `key_valid` and `busy`, go to `FIN`.
- **FIN:** `done=1` for exactly one cycle, then `IDLE`.
- **Start while busy:** `start` in `EMIT` or `FIN` is ignored, and `last_key` is not re-sampled.
- **Reset mid-sequence:** reset has priority over every other input. The sequence is abandoned; no `done` is produced.
- **Reset values:** `round_key=0`, `round_idx=0`, `key_valid=0`, `busy=0`, `done=0`, state `IDLE`.

## Timing

- **Start latency:** `start` accepted at edge N; the round-10 key is valid after edge N (one cycle).
- **Throughput:** one key per cycle with `key_ready` held high. The 11 keys occupy 11 consecutive cycles, and `done` is high on the 12th cycle.
- **Restart:** `start` is earliest accepted in the cycle after `done`, giving a minimum of 13 cycles start-to-start.
- **Critical path:** XOR, then RotWord/S-box, then XOR, from the state registers back to the state registers. This is one round per cycle, with no pipelining.
- **Stall:** `key_ready` low for any number of cycles leaves all outputs unchanged.

## Configuration

- **`INV_KEY_MIXCOL_EN` defined:**
  - The keys presented for rounds 9..1 are InvMixColumns of the schedule key, for the equivalent inverse cipher. InvMixColumns is applied per 32-bit column, combinationally before the output register.
  - Rounds 10 and 0 are emitted untransformed.
  - The internal state always holds the untransformed key.
- **Not defined:** all 11 keys are emitted untransformed, and no InvMixColumns logic is synthesized.
- **Both builds:** the handshake and timing are identical.

## Test plan

- **FIPS-197 key, ready always high:**
  - Stimulus: `start` with `last_key=d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - Required: idx10 = d014f9a8…, then idx9 = `ac7766f319fadc2128d12941575c006e`, …, idx0 = `2b7e151628aed2a6abf7158809cf4f3c`. Eleven consecutive valid cycles, then `done` for one cycle.
- **Zero key:**
  - Stimulus: `last_key=b4ef5bcb3e92e21123e951cf6f8f188e`.
  - Required: idx1 = `62636363626363636263636362636363`, idx0 = all zeros.
- **Backpressure:**
  - Stimulus: `key_ready` low for 3 cycles at idx7 and at idx0.
  - Required: `round_key` and `round_idx` hold during each stall. The sequence matches the unstalled run, and `done` comes only after the idx0 handshake.
- **Start while busy:**
  - Stimulus: pulse `start` with a different `last_key` at idx5.
  - Required: ignored; the original sequence completes unchanged.
- **Reset mid-sequence:**
  - Stimulus: `reset=0` at idx4.
  - Required: the next edge gives all outputs 0 and `IDLE`, with no `done`. A following `start` runs a full correct sequence.
- **With `INV_KEY_MIXCOL_EN` defined:**
  - Stimulus: FIPS-197 key.
  - Required: idx9 = InvMixColumns(`ac7766f3…`) per the bench's reference model; idx10 and idx0 are identical to the plain build.
